// File: rtl/mem_arbiter.sv
// Round-robin arbiter: NTT engine ports onto one memory port, in-order read tags.
// Optional grant counter: define MEM_ARBITER_PERF_EN.
module mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 48,
  parameter int DATA_W    = 64,
  parameter int TAG_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        arb_req,
  input  logic [NUM_CORES-1:0]        arb_we,
  input  logic [NUM_CORES*ADDR_W-1:0] arb_addr,
  input  logic [NUM_CORES*DATA_W-1:0] arb_wdata,
  output logic [NUM_CORES-1:0]        arb_gnt,
  output logic [NUM_CORES-1:0]        arb_valid,
  output logic [DATA_W-1:0]           arb_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        err_orphan,
  output logic [31:0]                 perf_gnt_count
);

  localparam int IW = $clog2(NUM_CORES);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0]        last_winner;
  logic [IW-1:0]        win;
  logic [NUM_CORES-1:0] cand;
  logic                 found;
  logic                 grant;
  logic                 slot_free;
  logic                 pop;
  logic                 push;
  logic                 can_push;
  logic [CW-1:0]        count;
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic [IW-1:0]        tags [TAG_DEPTH];

  assign slot_free = !mem_req || mem_ready;
  assign pop       = mem_rvalid && (count != '0);
  assign can_push  = (count != CW'(TAG_DEPTH)) || pop;

  // Reads drop out when no tag slot is free, so the rr search lands on the next write.
  assign cand = arb_req & ~arb_gnt & (arb_we | {NUM_CORES{can_push}});

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      idx = (int'(last_winner) + i) % NUM_CORES;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign grant = found && slot_free;
  assign push  = grant && !arb_we[win];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_gnt     <= '0;
      arb_valid   <= '0;
      arb_rdata   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err_orphan  <= 1'b0;
      last_winner <= IW'(NUM_CORES - 1);
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      arb_gnt <= grant ? (NUM_CORES'(1) << win) : '0;
      if (grant) begin
        mem_req     <= 1'b1;
        mem_we      <= arb_we[win];
        mem_addr    <= arb_addr[int'(win)*ADDR_W +: ADDR_W];
        mem_wdata   <= arb_wdata[int'(win)*DATA_W +: DATA_W];
        last_winner <= win;
      end else if (mem_ready) begin
        mem_req <= 1'b0;
      end
      arb_valid <= pop ? (NUM_CORES'(1) << tags[rptr]) : '0;
      if (pop) begin
        arb_rdata <= mem_rdata;
        rptr      <= rptr + PW'(1);
      end
      if (mem_rvalid && count == '0)
        err_orphan <= 1'b1;
      if (push)
        wptr <= wptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      tags[wptr] <= win;
  end

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_q <= '0;
    else if (grant)
      perf_q <= perf_q + 32'd1;
  end

  assign perf_gnt_count = perf_q;
`else
  assign perf_gnt_count = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, stalls, tag-full bypass, orphans.
// Drives inputs 1ns after rising edges and checks registered outputs there.
module tb_mem_arbiter;

  localparam int N = 4;
  localparam int A = 48;
  localparam int D = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   arb_req;
  logic [N-1:0]   arb_we;
  logic [N*A-1:0] arb_addr;
  logic [N*D-1:0] arb_wdata;
  logic [N-1:0]   arb_gnt;
  logic [N-1:0]   arb_valid;
  logic [D-1:0]   arb_rdata;
  logic           mem_req;
  logic           mem_we;
  logic [A-1:0]   mem_addr;
  logic [D-1:0]   mem_wdata;
  logic           mem_ready;
  logic           mem_rvalid;
  logic [D-1:0]   mem_rdata;
  logic           err_orphan;
  logic [31:0]    perf_gnt_count;

  int errors = 0;
  int checks = 0;
  int ngnt;
  logic [N-1:0] exp_v [8];

  mem_arbiter #(
    .NUM_CORES(N), .ADDR_W(A), .DATA_W(D), .TAG_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .arb_req(arb_req), .arb_we(arb_we),
    .arb_addr(arb_addr), .arb_wdata(arb_wdata),
    .arb_gnt(arb_gnt), .arb_valid(arb_valid),
    .arb_rdata(arb_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .err_orphan(err_orphan),
    .perf_gnt_count(perf_gnt_count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    arb_req    = '0;
    arb_we     = '0;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    arb_addr  = '0;
    arb_wdata = '0;
    for (int i = 0; i < N; i++) begin
      arb_addr[i*A +: A]  = A'(32'h100 * (i + 1));
      arb_wdata[i*D +: D] = D'(32'hA0 + i);
    end
    do_reset();
    check("rst_gnt", 64'(arb_gnt), 64'h0);
    check("rst_valid", 64'(arb_valid), 64'h0);
    check("rst_rdata", arb_rdata, 64'h0);
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_err", 64'(err_orphan), 64'h0);
    check("rst_perf", 64'(perf_gnt_count), 64'h0);

    // single read by core 2
    tick();
    arb_addr[2*A +: A] = A'(32'h1000);
    arb_req = 4'b0100;
    arb_we  = 4'b0000;
    tick();
    check("rd_gnt", 64'(arb_gnt), 64'h4);
    check("rd_mem_req", 64'(mem_req), 64'h1);
    check("rd_mem_addr", 64'(mem_addr), 64'h1000);
    check("rd_mem_we", 64'(mem_we), 64'h0);
    arb_req = '0;
    tick();
    check("rd_gnt_pulse", 64'(arb_gnt), 64'h0);
    check("rd_mem_req_clr", 64'(mem_req), 64'h0);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD;
    tick();
    check("rd_valid", 64'(arb_valid), 64'h4);
    check("rd_rdata", arb_rdata, 64'hDEAD);
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h0;
    tick();
    check("rd_valid_pulse", 64'(arb_valid), 64'h0);
    check("rd_rdata_hold", arb_rdata, 64'hDEAD);
    check("rd_no_orphan", 64'(err_orphan), 64'h0);
    arb_addr[2*A +: A] = A'(32'h300);

    // four writers from reset: 0,1,2,3,0
    do_reset();
    arb_req = 4'b1111;
    arb_we  = 4'b1111;
    tick();
    check("rr_g0", 64'(arb_gnt), 64'h1);
    check("rr_a0", 64'(mem_addr), 64'h100);
    check("rr_we0", 64'(mem_we), 64'h1);
    check("rr_wd0", mem_wdata, 64'hA0);
    tick();
    check("rr_g1", 64'(arb_gnt), 64'h2);
    check("rr_a1", 64'(mem_addr), 64'h200);
    tick();
    check("rr_g2", 64'(arb_gnt), 64'h4);
    tick();
    check("rr_g3", 64'(arb_gnt), 64'h8);
    check("rr_a3", 64'(mem_addr), 64'h400);
    tick();
    check("rr_g4", 64'(arb_gnt), 64'h1);

    // stall: memory not ready for five cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_gnt", 64'(arb_gnt), 64'h0);
      check("stall_req", 64'(mem_req), 64'h1);
      check("stall_addr", 64'(mem_addr), 64'h100);
    end
    mem_ready = 1'b1;
    tick();
    check("resume_gnt", 64'(arb_gnt), 64'h2);
    check("resume_addr", 64'(mem_addr), 64'h200);
    arb_req = '0;
    tick();
    tick();
    check("resume_idle", 64'(mem_req), 64'h0);

    // fill the tag FIFO with eight reads from cores 0 and 2
    do_reset();
    arb_req = 4'b0101;
    arb_we  = 4'b0000;
    ngnt = 0;
    for (int i = 0; i < 20 && ngnt < 8; i++) begin
      tick();
      ngnt += $countones(arb_gnt);
    end
    check("fill_count", 64'(ngnt), 64'd8);
    arb_req = 4'b1010;
    arb_we  = 4'b1000;
    tick();
    check("full_wr_gnt", 64'(arb_gnt), 64'h8);
    check("full_wr_we", 64'(mem_we), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_rd_blocked", 64'(arb_gnt[1]), 64'h0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h11;
    tick();
    check("full_pop_valid", 64'(arb_valid), 64'h1);
    check("full_pop_rdata", arb_rdata, 64'h11);
    check("full_push_gnt", 64'(arb_gnt), 64'h2);
    arb_req = '0;
    exp_v[0] = 4'b0100; exp_v[1] = 4'b0001;
    exp_v[2] = 4'b0100; exp_v[3] = 4'b0001;
    exp_v[4] = 4'b0100; exp_v[5] = 4'b0001;
    exp_v[6] = 4'b0100; exp_v[7] = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      mem_rdata = 64'(32'h20 + i);
      tick();
      check("drain_valid", 64'(arb_valid), 64'(exp_v[i]));
      check("drain_rdata", arb_rdata, 64'(32'h20 + i));
    end
    check("drain_no_orphan", 64'(err_orphan), 64'h0);

    // orphan response on empty FIFO
    mem_rdata = 64'hBAD;
    tick();
    check("orphan_valid", 64'(arb_valid), 64'h0);
    check("orphan_err", 64'(err_orphan), 64'h1);
    check("orphan_rdata", arb_rdata, 64'h27);
    mem_rvalid = 1'b0;
    tick();
    tick();
    check("orphan_sticky", 64'(err_orphan), 64'h1);
    do_reset();
    check("orphan_clr", 64'(err_orphan), 64'h0);

    // reset discards an outstanding read tag
    arb_req = 4'b0001;
    arb_we  = 4'b0000;
    tick();
    check("mid_gnt", 64'(arb_gnt), 64'h1);
    do_reset();
    mem_rvalid = 1'b1;
    tick();
    check("mid_valid", 64'(arb_valid), 64'h0);
    check("mid_orphan", 64'(err_orphan), 64'h1);
    mem_rvalid = 1'b0;

    // ten grants for the performance counter
    do_reset();
    arb_req = 4'b1111;
    arb_we  = 4'b1111;
    for (int i = 0; i < 10; i++) tick();
    arb_req = '0;
    tick();
    tick();
`ifdef MEM_ARBITER_PERF_EN
    check("perf_count", 64'(perf_gnt_count), 64'd10);
`else
    check("perf_count", 64'(perf_gnt_count), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
